// File: rtl/data_ram_bytelane_if.sv
// Request/response bundle for the byte-lane data RAM.
interface data_ram_bytelane_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );
endinterface

// File: rtl/data_ram_bytelane.sv
// Word-organised byte-lane data RAM with RV32 load/store decode and optional post-reset clear.
module data_ram_bytelane #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_bytelane_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  clr_cnt;
    logic [IDX_W-1:0]  clr_cnt_nxt;
    logic              clr_we;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              legal;
    logic              aligned;
    logic              fault;
    logic              store_en;
    logic [IDX_W-1:0]  widx;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       lane_data;
    logic [31:0]       rd_shift;
    logic [31:0]       load_data;

    // Upper address bits alias; fold them so they are visibly consumed.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    // State and clear counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear sequencing: one word per cycle, then park in IDLE until reset.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + IDX_W'(1);
                if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign bus.busy      = (state == ST_CLEAR);
    assign accept        = bus.req_valid && bus.req_ready;
    assign widx          = bus.req_addr[IDX_W+1:2];
    assign off           = bus.req_addr[1:0];

    // Size legality and natural-alignment check.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        case (bus.req_size)
            3'b000: legal = 1'b1;
            3'b001: begin legal = 1'b1;           aligned = !off[0];      end
            3'b010: begin legal = 1'b1;           aligned = (off == 2'b00); end
            3'b100: legal = !bus.req_we;
            3'b101: begin legal = !bus.req_we;    aligned = !off[0];      end
            default: legal = 1'b0;
        endcase
        fault = !legal || !aligned;
    end

    assign store_en = accept && bus.req_we && !fault;

    // Store lane enables and replicated lane data.
    always_comb begin
        be        = 4'b0000;
        lane_data = bus.req_wdata;
        case (bus.req_size[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                lane_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Load: align addressed bytes to bit 0, then extend by size.
    always_comb begin
        rd_shift  = mem[widx] >> {off, 3'b000};
        load_data = '0;
        case (bus.req_size)
            3'b000: load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001: load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010: load_data = rd_shift;
            3'b100: load_data = {24'h0, rd_shift[7:0]};
            3'b101: load_data = {16'h0, rd_shift[15:0]};
            default: load_data = '0;
        endcase
    end

    // Array writes: clear pass or byte-enabled store; contents are never reset.
    always_ff @(posedge clk) begin
        if (clr_we && !rst) begin
            mem[clr_cnt] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Registered one-cycle response; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_fault <= accept && fault;
            bus.rsp_rdata <= (accept && !fault && !bus.req_we) ? load_data : '0;
        end
    end
endmodule

// File: doc/data_ram_bytelane.md
# data_ram_bytelane

Word-organised, byte-lane data RAM for the RISC-V core's MEM stage, replacing the flat byte-array data memory. It takes load and store requests over a valid/ready handshake and returns a registered response one cycle later. It decodes RV32 load/store sizes from funct3, sign- or zero-extends loads, and flags misaligned or illegal accesses. An optional post-reset clear sequencer zeroes the whole array before the first request is accepted.

## Interface
- ADDR_W, 32, request address width.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two, at least 4; the default gives 16 kB.
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset; when 0 no clear pass runs.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended to 32 bits.
- rsp_fault  out  1  request rejected: misaligned or illegal size.
- busy  out  1  clear pass in progress.

## Operation
- Word index is req_addr[log2(DEPTH_WORDS)+1:2].
- Byte offset is req_addr[1:0].
- Higher address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- FSM has two states, CLEAR and IDLE.
  - Reset state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - In CLEAR, a counter writes word 0 … DEPTH_WORDS-1 with 0, one word per cycle, and busy=1.
  - After the edge that clears the last word, the FSM moves to IDLE and stays there until reset.
- req_ready = (state==IDLE) && !rst. A request is accepted on an edge where req_valid && req_ready.
- Legal sizes:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is a fault, including 100/101 with req_we=1.
- Alignment:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - B/BU is always aligned.
  - A violation is a fault.
- Store, no fault:
  - Byte enables: B → lane addr[1:0]; H → lanes {addr[1],0} and {addr[1],1}; W → all four lanes.
  - Lane data is req_wdata[7:0] replicated (B), req_wdata[15:0] replicated (H), or req_wdata (W).
  - Only enabled lanes are written.
- Load, no fault:
  - Read the word and shift right by 8*addr[1:0].
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- Response:
  - Every accepted request, load or store, produces exactly one rsp_valid pulse.
  - A store response has rsp_rdata=0 and rsp_fault=0.
  - A faulting request writes nothing and responds with rsp_rdata=0, rsp_fault=1.
- No backpressure on the response side; the consumer must take it.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - busy=CLEAR_ON_RESET.
  - Clear counter=0.
- Clear duration is exactly DEPTH_WORDS cycles after rst deasserts; req_ready rises on the cycle after the last clear edge.
- With CLEAR_ON_RESET=0, req_ready=1 in the first cycle rst is low.
- Latency: the request is accepted at edge N. rsp_valid, rsp_rdata and rsp_fault are valid after edge N, are sampled at edge N+1, and are held for that single cycle.
- Throughput is one request per cycle.
- rsp_valid=0 in any cycle that follows an edge with no accepted request.
- Stores write at the acceptance edge. A load accepted on the next edge to the same word returns the new data; no bypass logic is needed.
- Reset mid-clear: the counter returns to 0 and the full DEPTH_WORDS clear repeats.
- Reset with a response pending: rsp_valid clears immediately and asynchronously, and the response is dropped.
- Array contents are not otherwise reset.

## Test plan
- DEPTH_WORDS=16, CLEAR_ON_RESET=1 → busy=1 and req_ready=0 for exactly 16 cycles after reset release; then LW 0x3C → rsp_rdata=0x00000000.
- SW 0x100 data 0xDEADBEEF, then:
  - LB 0x101 → 0xFFFFFFBE
  - LBU 0x103 → 0x000000DE
  - LH 0x102 → 0xFFFFDEAD
  - LHU 0x100 → 0x0000BEEF
- SW 0x200 data 0, then SB 0x201 data 0x12345678 → LW 0x200 = 0x00007800; then SH 0x202 data 0xCAFE → LW 0x200 = 0xCAFE7800.
- Fault cases:
  - LW 0x102 → rsp_fault=1, rsp_rdata=0.
  - SH 0x103 data 0xFFFF → rsp_fault=1, and LW 0x100 is unchanged.
  - Size 011 → rsp_fault=1.
  - SBU (req_we=1, size 100) → rsp_fault=1.
- Back-to-back SW 0x40 data 0xA5A5A5A5 then LW 0x40 on the next cycle → LW returns 0xA5A5A5A5; rsp_valid is high two consecutive cycles.
- Reset mid-operation:
  - rst asserted at clear cycle 5 → busy stays 1 for a full 16 cycles after re-release.
  - rst asserted the cycle after an accepted LW → rsp_valid=0 immediately.
